srp16_boot_loader: RTL and testbench

Byte-stream program loader that writes SRP16 program memory before the CPU fetches from it. It sits between a byte-serial receiver (UART RX) and the byte-wide memory bus. It holds the CPU in reset while a frame is loading, verifies a checksum, and releases the CPU once the image is in memory.

---
 rtl/srp16_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_srp16_boot_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srp16_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : srp16_boot_loader
// Purpose  : Byte-stream program loader for SRP16 program memory. Parses
//            MAGIC/ADDR/LEN/DATA/CSUM frames from a byte receiver, writes
//            the payload over a byte-wide memory bus, verifies an additive
//            checksum and holds the CPU in reset until an image is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module srp16_boot_loader #(
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_write,
  input  logic        mem_busy,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR_H = 4'd1,
    S_ADDR_L = 4'd2,
    S_LEN_H  = 4'd3,
    S_LEN_L  = 4'd4,
    S_DATA   = 4'd5,
    S_WRITE  = 4'd6,
    S_CSUM   = 4'd7,
    S_RUN    = 4'd8
  } state_t;

  // A zero TIMEOUT disables the idle watchdog entirely.
  localparam logic        c_tmo_en   = (TIMEOUT != 16'd0);
  localparam logic [15:0] c_tmo_last = TIMEOUT - 16'd1;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;      // next byte address to be written
  logic [15:0] r_len_rem;   // frame length, then bytes still to write
  logic [15:0] r_tmo_cnt;   // idle cycles since last accept in a timed state
  logic [7:0]  r_sum;       // running sum of payload bytes
  logic [7:0]  w_sum_next;
  logic        w_accept;
  logic        w_timed;
  logic        w_timeout;
  logic        w_magic;
  logic        w_len_zero;
  logic        w_csum_ok;

  // rx_ready is low in WRITE and while reset is applied, so no byte is taken then.
  assign rx_ready   = (r_state != S_WRITE) && !reset;
  assign w_accept   = rx_valid && rx_ready;
  assign w_magic    = (rx_data == MAGIC);
  assign w_sum_next = r_sum + rx_data;
  assign w_csum_ok  = (w_sum_next == 8'h00);
  assign w_len_zero = ({r_len_rem[15:8], rx_data} == 16'd0);
  assign w_timed    = (r_state == S_ADDR_H) || (r_state == S_ADDR_L) ||
                      (r_state == S_LEN_H)  || (r_state == S_LEN_L)  ||
                      (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_timeout  = c_tmo_en && w_timed && !w_accept && (r_tmo_cnt == c_tmo_last);

  // State register; async reset aborts any frame and drops the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    mem_write = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept && w_magic) w_next = S_ADDR_H;
      S_ADDR_H: if (w_accept) w_next = S_ADDR_L;
      S_ADDR_L: if (w_accept) w_next = S_LEN_H;
      S_LEN_H:  if (w_accept) w_next = S_LEN_L;
      S_LEN_L:  if (w_accept) w_next = w_len_zero ? S_CSUM : S_DATA;
      S_DATA:   if (w_accept) w_next = S_WRITE;
      S_WRITE: begin
        mem_write = 1'b1;
        if (!mem_busy) w_next = (r_len_rem == 16'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM:   if (w_accept) w_next = w_csum_ok ? S_RUN : S_IDLE;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (w_accept && w_magic) w_next = S_ADDR_H;
      end
      default:  w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Header capture, payload latch, address/length stepping and checksum sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= 16'd0;
      r_len_rem <= 16'd0;
      r_sum     <= 8'd0;
      mem_addr  <= 16'd0;
      mem_dout  <= 8'd0;
    end else begin
      case (r_state)
        S_ADDR_H: if (w_accept) r_addr[15:8] <= rx_data;
        S_ADDR_L: if (w_accept) r_addr[7:0] <= rx_data;
        S_LEN_H:  if (w_accept) r_len_rem[15:8] <= rx_data;
        S_LEN_L: begin
          if (w_accept) begin
            r_len_rem[7:0] <= rx_data;
            r_sum          <= 8'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            mem_dout <= rx_data;
            mem_addr <= r_addr;
            r_sum    <= w_sum_next;
          end
        end
        S_WRITE: begin
          if (!mem_busy) begin
            r_addr    <= r_addr + 16'd1;
            r_len_rem <= r_len_rem - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Idle watchdog: counts cycles without an accept, cleared on accept or state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_tmo_cnt <= 16'd0;
    else if (!w_timed || w_accept || (w_next != r_state)) r_tmo_cnt <= 16'd0;
    else                                           r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // Sticky error: set by bad checksum or timeout, cleared by the next MAGIC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (w_timeout || ((r_state == S_CSUM) && w_accept && !w_csum_ok)) begin
      error <= 1'b1;
    end else if (w_accept && w_magic && ((r_state == S_IDLE) || (r_state == S_RUN))) begin
      error <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srp16_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_srp16_boot_loader
// Purpose  : Self-checking bench for srp16_boot_loader: table of directed
//            frames, hand sequences for reload/timeout/async reset, and
//            random frames checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srp16_boot_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_write;
  logic        mem_busy;
  logic        cpu_reset;
  logic        done;
  logic        error;

  srp16_boot_loader #(.MAGIC(8'hA5), .TIMEOUT(16'd20)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_write (mem_write),
    .mem_busy  (mem_busy),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][7:0] fb;       // frame bytes, fb[0] sent first
    logic [7:0]       n;        // number of bytes in the frame
    logic [7:0]       stall;    // busy cycles applied to the first write(s)
    logic             exp_done;
    logic             exp_err;
    logic [7:0]       exp_hi;   // cycles with mem_write high
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          stall_budget = 0;
  bit          rand_stall = 1'b0;
  int          hi_cnt  = 0;
  int          ovl_cnt = 0;
  logic [23:0] wr_q[$];   // observed writes {addr, data}
  logic [23:0] exp_q[$];  // modelled writes {addr, data}
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int n, input logic [127:0] v, input int stall,
                              input bit d, input bit e, input int hi);
    vec_t r;
    r = '0;
    for (int i = 0; i < n; i++) r.fb[i] = v[8*(n-1-i) +: 8];
    r.n = 8'(n); r.stall = 8'(stall); r.exp_done = d; r.exp_err = e; r.exp_hi = 8'(hi);
    return r;
  endfunction

  // Frame-level model: payload lands at base+i (16-bit wrap); frame is good
  // when payload bytes plus checksum sum to zero modulo 256.
  task automatic model_frame(input logic [15:0][7:0] fb, output bit ok);
    logic [15:0] base, len;
    logic [7:0]  s;
    base = {fb[1], fb[2]};
    len  = {fb[3], fb[4]};
    s    = 8'h00;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({16'(base + 16'(i)), fb[5+i]});
      s = s + fb[5+i];
    end
    s  = s + fb[5 + int'(len)];
    ok = (s == 8'h00);
  endtask

  // Memory side: applies stalls, records completed writes, counts strobe cycles.
  initial begin
    mem_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_write && stall_budget > 0) begin
        mem_busy = 1'b1;
        stall_budget--;
      end else if (mem_write && rand_stall && ($urandom_range(0, 2) == 0)) begin
        mem_busy = 1'b1;
      end else begin
        mem_busy = 1'b0;
      end
      if (mem_write) hi_cnt++;
      if (mem_write && rx_ready) ovl_cnt++;
      if (!reset && mem_write && !mem_busy) wr_q.push_back({mem_addr, mem_dout});
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (rx_ready) break;
      k++;
      if (k > 200) begin
        n_checks++;
        $display("FAIL rx_ready_wait: byte %0h never accepted within 200 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0][7:0] fb, input int n, input int maxgap);
    for (int i = 0; i < n; i++) send_byte(fb[i], int'($urandom_range(0, maxgap)));
  endtask

  task automatic check_result(input string tag, input bit exp_done, input bit exp_err);
    int m;
    @(negedge clk);
    check({tag, ".done"},      {31'd0, done},      {31'd0, exp_done});
    check({tag, ".error"},     {31'd0, error},     {31'd0, exp_err});
    check({tag, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    check({tag, ".nwrites"},   wr_q.size(),        exp_q.size());
    m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s.write%0d", tag, i), {8'd0, wr_q[i]}, {8'd0, exp_q[i]});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    vecs[0] = mk(9, {8'hA5,8'h01,8'h00,8'h00,8'h03,8'h11,8'h22,8'h33,8'h9A}, 0, 1, 0, 3);
    vecs[1] = mk(9, {8'hA5,8'h01,8'h00,8'h00,8'h03,8'h11,8'h22,8'h33,8'h98}, 0, 0, 1, 3);
    vecs[2] = mk(9, {8'hA5,8'h01,8'h00,8'h00,8'h03,8'h11,8'h22,8'h33,8'h9A}, 0, 1, 0, 3);
    vecs[3] = mk(8, {8'hA5,8'hFF,8'hFF,8'h00,8'h02,8'hAA,8'h55,8'h01}, 5, 1, 0, 7);
    vecs[4] = mk(7, {8'hA5,8'h00,8'h10,8'h00,8'h01,8'h7E,8'h82}, 50, 1, 0, 51);
    vecs[5] = mk(6, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0, 0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.rx_ready",  {31'd0, rx_ready},  32'd0);
    check("rst.mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst.mem_dout",  {24'd0, mem_dout},  32'd0);
    check("rst.mem_write", {31'd0, mem_write}, 32'd0);
    check("rst.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst.done",      {31'd0, done},      32'd0);
    check("rst.error",     {31'd0, error},     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle.rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed frame table
    for (int k = 0; k < 6; k++) begin
      wr_q.delete();
      hi_cnt       = 0;
      stall_budget = int'(vecs[k].stall);
      model_frame(vecs[k].fb, ok);
      run_frame(vecs[k].fb, int'(vecs[k].n), 0);
      check_result($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err);
      check($sformatf("vec%0d.hi_cycles", k), hi_cnt, {24'd0, vecs[k].exp_hi});
      @(posedge clk); #1;
    end

    // Noise in RUN is ignored
    wr_q.delete();
    send_byte(8'h3C, 0);
    @(negedge clk);
    check("noise.done",      {31'd0, done},      32'd1);
    check("noise.cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("noise.nwrites",   wr_q.size(),        32'd0);

    // Reload: MAGIC in RUN raises cpu_reset and drops done on the next cycle
    @(posedge clk); #1;
    rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    check("reload.done_before", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("reload.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("reload.done",      {31'd0, done},      32'd0);

    // Timeout: ADDR_H byte then silence; error on the 20th idle edge
    @(posedge clk); #1;
    send_byte(8'h00, 0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("tmo.error_early", {31'd0, error}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tmo.error",     {31'd0, error},     32'd1);
    check("tmo.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("tmo.done",      {31'd0, done},      32'd0);
    check("tmo.rx_ready",  {31'd0, rx_ready},  32'd1);
    @(posedge clk); #1;

    // Random frames with noise prefix, random gaps and random memory stalls
    rand_stall = 1'b1;
    for (int f = 0; f < 8; f++) begin
      logic [15:0][7:0] fb;
      int               len;
      logic [7:0]       s;
      logic [7:0]       noise;
      fb  = '0;
      len = int'($urandom_range(1, 8));
      s   = 8'h00;
      fb[0] = 8'hA5;
      fb[1] = 8'($urandom); fb[2] = 8'($urandom);
      fb[3] = 8'h00;        fb[4] = 8'(len);
      for (int i = 0; i < len; i++) begin
        fb[5+i] = 8'($urandom);
        s = s + fb[5+i];
      end
      fb[5+len] = 8'h00 - s;
      if ($urandom_range(0, 1) == 0) fb[5+len] = fb[5+len] + 8'($urandom_range(1, 255));
      noise = 8'($urandom);
      if (noise == 8'hA5) noise = 8'h3C;
      wr_q.delete();
      model_frame(fb, ok);
      send_byte(noise, 0);
      run_frame(fb, len + 6, 3);
      check_result($sformatf("rnd%0d", f), ok, !ok);
      @(posedge clk); #1;
    end
    rand_stall = 1'b0;

    // Async reset while a write is held by a stalled memory
    stall_budget = 1000;
    run_frame(mk(6, {8'hA5,8'h00,8'h40,8'h00,8'h03,8'h11}, 0, 0, 0, 0).fb, 6, 0);
    wr_q.delete();
    @(negedge clk);
    check("arst.pre_write", {31'd0, mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst.mem_write", {31'd0, mem_write}, 32'd0);
    check("arst.rx_ready",  {31'd0, rx_ready},  32'd0);
    check("arst.mem_addr",  {16'd0, mem_addr},  32'd0);
    check("arst.mem_dout",  {24'd0, mem_dout},  32'd0);
    check("arst.cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("arst.done",      {31'd0, done},      32'd0);
    check("arst.error",     {31'd0, error},     32'd0);
    @(posedge clk); #1;
    stall_budget = 0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("arst.nwrites_after", wr_q.size(), 32'd0);
    check("arst.idle_write",    {31'd0, mem_write}, 32'd0);

    check("rx_ready_during_write", ovl_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
